// File: rtl/bsg_manycore_host_req_throttle_if.sv
// Host request / endpoint handshake bundle for the request throttle.
// The slave modport is the throttle; the master modport is the host/endpoint side.
interface bsg_manycore_host_req_throttle_if #(
    parameter int fifo_width_p           = 32,
    parameter int credit_counter_width_p = 6,
    parameter int count_width_p          = 32
);
    logic                              in_v_i;
    logic [fifo_width_p-1:0]           in_data_i;
    logic                              in_ready_o;
    logic                              out_v_o;
    logic [fifo_width_p-1:0]           out_data_o;
    logic                              out_ready_i;
    logic [credit_counter_width_p-1:0] out_credits_used_i;
    logic                              fence_v_i;
    logic                              fence_ready_o;
    logic                              fence_done_o;
    logic [count_width_p-1:0]          sent_count_o;

    modport slave (
        input  in_v_i, in_data_i, out_ready_i, out_credits_used_i, fence_v_i,
        output in_ready_o, out_v_o, out_data_o, fence_ready_o, fence_done_o, sent_count_o
    );

    modport master (
        output in_v_i, in_data_i, out_ready_i, out_credits_used_i, fence_v_i,
        input  in_ready_o, out_v_o, out_data_o, fence_ready_o, fence_done_o, sent_count_o
    );
endinterface

// File: rtl/bsg_manycore_host_req_throttle.sv
// Buffers host requests in a 2-entry FIFO, issues them only while endpoint credits remain,
// and implements a fence that waits for all earlier requests and credits to drain.
module bsg_manycore_host_req_throttle #(
    parameter int fifo_width_p           = 32,
    parameter int credit_counter_width_p = 6,
    parameter int count_width_p          = 32
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic reset_done_i,
    bsg_manycore_host_req_throttle_if.slave io
);
    localparam int cw_lp = credit_counter_width_p;
    localparam logic [cw_lp:0] max_credits_lp = {1'b0, {cw_lp{1'b1}}};

    typedef enum logic [1:0] {
        e_pass  = 2'd0,
        e_drain = 2'd1,
        e_done  = 2'd2
    } state_e;

    state_e                    r_state;
    state_e                    w_state_n;
    logic [fifo_width_p-1:0]   r_mem [2];
    logic                      r_wptr;
    logic                      r_rptr;
    logic [1:0]                r_count;
    logic                      r_sent_last;
    logic [count_width_p-1:0]  r_sent_count;
    logic                      r_in_wait;

    logic w_full;
    logic w_empty;
    logic w_credit_ok;
    logic w_enq;
    logic w_deq;
    logic w_drained;

    assign w_full  = (r_count == 2'd2);
    assign w_empty = (r_count == 2'd0);

    // The endpoint's count lags by a cycle, so the packet sent last cycle is counted here.
    assign w_credit_ok = ({1'b0, io.out_credits_used_i} + {{cw_lp{1'b0}}, r_sent_last})
                         < max_credits_lp;

    assign io.in_ready_o    = ~w_full & ~reset_i & (r_state == e_pass);
    assign io.out_v_o       = ~w_empty & w_credit_ok & reset_done_i & (r_state != e_done) & ~reset_i;
    assign io.out_data_o    = r_mem[r_rptr];
    assign io.fence_ready_o = (r_state == e_pass) & ~reset_i;
    assign io.fence_done_o  = (r_state == e_done) & ~reset_i;
    assign io.sent_count_o  = r_sent_count;

    assign w_enq     = io.in_v_i & io.in_ready_o;
    assign w_deq     = io.out_v_o & io.out_ready_i;
    assign w_drained = w_empty & ~r_sent_last & (io.out_credits_used_i == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= e_pass;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_count      <= 2'd0;
            r_sent_last  <= 1'b0;
            r_sent_count <= '0;
            r_in_wait    <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_wptr       <= r_wptr ^ w_enq;
            r_rptr       <= r_rptr ^ w_deq;
            r_count      <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
            r_sent_last  <= w_deq;
            r_sent_count <= r_sent_count + {{(count_width_p-1){1'b0}}, w_deq};
            r_in_wait    <= io.in_v_i & ~io.in_ready_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr] <= io.in_data_i;
        end
    end

    // A packet accepted alongside the fence is already in the buffer, so it drains first.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            e_pass:  if (io.fence_v_i) w_state_n = e_drain;
            e_drain: if (w_drained)    w_state_n = e_done;
            e_done:  w_state_n = e_pass;
            default: w_state_n = e_pass;
        endcase
    end

    always @(negedge clk_i) begin
        if (reset_i === 1'b0) begin
            assert (!(io.out_v_o & io.out_ready_i & ({1'b0, io.out_credits_used_i} == max_credits_lp)))
                else $fatal(1, "request issued with all endpoint credits in use");
            assert (!(r_in_wait & ~io.in_v_i))
                else $fatal(1, "in_v_i withdrawn before being accepted");
        end
    end
endmodule

// File: tb/tb_bsg_manycore_host_req_throttle.sv
module tb_bsg_manycore_host_req_throttle;
    logic clk_i = 1'b0;
    logic reset_i;
    logic reset_done_i;
    int   n_tests = 0;
    int   n_fail  = 0;

    bsg_manycore_host_req_throttle_if #(
        .fifo_width_p(8), .credit_counter_width_p(3), .count_width_p(32)
    ) bus ();

    bsg_manycore_host_req_throttle #(
        .fifo_width_p(8), .credit_counter_width_p(3), .count_width_p(32)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .reset_done_i (reset_done_i),
        .io           (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic nedge();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        reset_i = 1'b1; reset_done_i = 1'b0;
        bus.in_v_i = 1'b0; bus.in_data_i = '0; bus.out_ready_i = 1'b0;
        bus.out_credits_used_i = '0; bus.fence_v_i = 1'b0;
        tick(); tick();
        nedge();
        n_tests++;
        if ({bus.in_ready_o, bus.out_v_o, bus.fence_ready_o, bus.fence_done_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_held: got rdy/v/frdy/fdone=%b want 0000",
                     {bus.in_ready_o, bus.out_v_o, bus.fence_ready_o, bus.fence_done_o});
        end
        tick(); reset_i = 1'b0;
        nedge();
        n_tests++;
        if ({bus.in_ready_o, bus.fence_ready_o, bus.out_v_o, bus.fence_done_o} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_after: got rdy/frdy/v/fdone=%b want 1100",
                     {bus.in_ready_o, bus.fence_ready_o, bus.out_v_o, bus.fence_done_o});
        end
        n_tests++;
        if (bus.sent_count_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", bus.sent_count_o);
        end
        reset_done_i = 1'b1;
    endtask

    task automatic test_basic();
        tick(); bus.out_ready_i = 1'b1; bus.out_credits_used_i = 3'd0;
        bus.in_v_i = 1'b1; bus.in_data_i = 8'hA1;
        nedge();
        n_tests++;
        if ({bus.in_ready_o, bus.out_v_o} !== 2'b10) begin
            n_fail++; $display("FAIL basic_first: got rdy/v=%b want 10", {bus.in_ready_o, bus.out_v_o});
        end
        tick(); bus.in_data_i = 8'hB2;
        nedge();
        n_tests++;
        if ({bus.out_v_o, bus.out_data_o} !== {1'b1, 8'hA1}) begin
            n_fail++; $display("FAIL basic_A: got v=%b d=%h want v=1 d=a1", bus.out_v_o, bus.out_data_o);
        end
        tick(); bus.in_data_i = 8'hC3;
        nedge();
        n_tests++;
        if ({bus.out_v_o, bus.out_data_o} !== {1'b1, 8'hB2}) begin
            n_fail++; $display("FAIL basic_B: got v=%b d=%h want v=1 d=b2", bus.out_v_o, bus.out_data_o);
        end
        tick(); bus.in_v_i = 1'b0;
        nedge();
        n_tests++;
        if ({bus.out_v_o, bus.out_data_o} !== {1'b1, 8'hC3}) begin
            n_fail++; $display("FAIL basic_C: got v=%b d=%h want v=1 d=c3", bus.out_v_o, bus.out_data_o);
        end
        tick();
        nedge();
        n_tests++;
        if ({bus.out_v_o, bus.sent_count_o} !== {1'b0, 32'd3}) begin
            n_fail++; $display("FAIL basic_end: got v=%b cnt=%0d want v=0 cnt=3", bus.out_v_o, bus.sent_count_o);
        end
    endtask

    task automatic test_credit_cap();
        tick(); bus.out_credits_used_i = 3'd6; bus.in_v_i = 1'b1; bus.in_data_i = 8'hD4;
        nedge();
        tick(); bus.in_data_i = 8'hE5;
        nedge();
        n_tests++;
        if ({bus.out_v_o, bus.out_data_o} !== {1'b1, 8'hD4}) begin
            n_fail++; $display("FAIL credit_one: got v=%b d=%h want v=1 d=d4", bus.out_v_o, bus.out_data_o);
        end
        tick(); bus.in_v_i = 1'b0; bus.out_credits_used_i = 3'd7;
        nedge();
        n_tests++;
        if (bus.out_v_o !== 1'b0) begin
            n_fail++; $display("FAIL credit_lag_block: got v=%b want 0", bus.out_v_o);
        end
        tick();
        nedge();
        n_tests++;
        if (bus.out_v_o !== 1'b0) begin
            n_fail++; $display("FAIL credit_full_block: got v=%b want 0", bus.out_v_o);
        end
        tick(); bus.out_credits_used_i = 3'd6;
        nedge();
        n_tests++;
        if ({bus.out_v_o, bus.out_data_o} !== {1'b1, 8'hE5}) begin
            n_fail++; $display("FAIL credit_resume: got v=%b d=%h want v=1 d=e5", bus.out_v_o, bus.out_data_o);
        end
        tick(); bus.out_credits_used_i = 3'd7;
        nedge();
        n_tests++;
        if (bus.sent_count_o !== 32'd5) begin
            n_fail++; $display("FAIL credit_count: got %0d want 5", bus.sent_count_o);
        end
        tick(); bus.out_credits_used_i = 3'd0;
    endtask

    task automatic test_backpressure();
        tick(); bus.out_ready_i = 1'b0; bus.in_v_i = 1'b1; bus.in_data_i = 8'hF6;
        nedge();
        tick(); bus.in_data_i = 8'h17;
        nedge();
        n_tests++;
        if ({bus.in_ready_o, bus.out_v_o, bus.out_data_o} !== {2'b11, 8'hF6}) begin
            n_fail++; $display("FAIL bp_second: got rdy=%b v=%b d=%h want 1 1 f6",
                               bus.in_ready_o, bus.out_v_o, bus.out_data_o);
        end
        tick(); bus.in_data_i = 8'h28;
        nedge();
        n_tests++;
        if (bus.in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_full: got rdy=%b want 0", bus.in_ready_o);
        end
        tick();
        nedge();
        n_tests++;
        if (bus.in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_full_hold: got rdy=%b want 0", bus.in_ready_o);
        end
        tick(); bus.out_ready_i = 1'b1;
        nedge();
        n_tests++;
        if ({bus.in_ready_o, bus.out_v_o, bus.out_data_o} !== {2'b01, 8'hF6}) begin
            n_fail++; $display("FAIL bp_release: got rdy=%b v=%b d=%h want 0 1 f6",
                               bus.in_ready_o, bus.out_v_o, bus.out_data_o);
        end
        tick();
        nedge();
        n_tests++;
        if ({bus.in_ready_o, bus.out_data_o} !== {1'b1, 8'h17}) begin
            n_fail++; $display("FAIL bp_third_accept: got rdy=%b d=%h want 1 17", bus.in_ready_o, bus.out_data_o);
        end
        tick(); bus.in_v_i = 1'b0;
        nedge();
        n_tests++;
        if ({bus.out_v_o, bus.out_data_o} !== {1'b1, 8'h28}) begin
            n_fail++; $display("FAIL bp_third_issue: got v=%b d=%h want 1 28", bus.out_v_o, bus.out_data_o);
        end
        tick();
        nedge();
        n_tests++;
        if ({bus.out_v_o, bus.sent_count_o} !== {1'b0, 32'd8}) begin
            n_fail++; $display("FAIL bp_end: got v=%b cnt=%0d want 0 8", bus.out_v_o, bus.sent_count_o);
        end
    endtask

    task automatic test_fence();
        int pulses = 0;
        tick(); bus.out_ready_i = 1'b0; bus.in_v_i = 1'b1; bus.in_data_i = 8'h39;
        tick(); bus.in_data_i = 8'h4A;
        tick(); bus.in_v_i = 1'b0; bus.fence_v_i = 1'b1;
        nedge();
        n_tests++;
        if ({bus.fence_ready_o, bus.in_ready_o} !== 2'b10) begin
            n_fail++; $display("FAIL fence_offer: got frdy/rdy=%b want 10", {bus.fence_ready_o, bus.in_ready_o});
        end
        tick(); bus.fence_v_i = 1'b0; bus.out_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            bus.out_credits_used_i = (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : (k < 5) ? 3'd2 : 3'd0;
            nedge();
            if (bus.fence_done_o === 1'b1) pulses++;
            n_tests++;
            if ({bus.fence_done_o, bus.in_ready_o, bus.fence_ready_o} !== {k == 6, k >= 7, k >= 7}) begin
                n_fail++; $display("FAIL fence_cycle%0d: got done/rdy/frdy=%b want %b", k,
                                   {bus.fence_done_o, bus.in_ready_o, bus.fence_ready_o},
                                   {k == 6, k >= 7, k >= 7});
            end
            if (k < 2) begin
                n_tests++;
                if ({bus.out_v_o, bus.out_data_o} !== {1'b1, (k == 0) ? 8'h39 : 8'h4A}) begin
                    n_fail++; $display("FAIL fence_drain%0d: got v=%b d=%h", k, bus.out_v_o, bus.out_data_o);
                end
            end
        end
        n_tests++;
        if ({pulses, bus.sent_count_o} !== {32'd1, 32'd10}) begin
            n_fail++; $display("FAIL fence_summary: got pulses=%0d cnt=%0d want 1 10", pulses, bus.sent_count_o);
        end
    endtask

    task automatic test_simul();
        tick(); bus.in_v_i = 1'b1; bus.in_data_i = 8'h5B; bus.fence_v_i = 1'b1;
        nedge();
        n_tests++;
        if ({bus.in_ready_o, bus.fence_ready_o} !== 2'b11) begin
            n_fail++; $display("FAIL simul_accept: got rdy/frdy=%b want 11", {bus.in_ready_o, bus.fence_ready_o});
        end
        tick(); bus.in_v_i = 1'b0; bus.fence_v_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            nedge();
            n_tests++;
            if ({bus.fence_done_o, bus.sent_count_o} !== {k == 3, (k == 0) ? 32'd10 : 32'd11}) begin
                n_fail++; $display("FAIL simul_cycle%0d: got done=%b cnt=%0d", k, bus.fence_done_o, bus.sent_count_o);
            end
            if (k == 0) begin
                n_tests++;
                if ({bus.out_v_o, bus.out_data_o} !== {1'b1, 8'h5B}) begin
                    n_fail++; $display("FAIL simul_issue: got v=%b d=%h want 1 5b", bus.out_v_o, bus.out_data_o);
                end
            end
        end
    endtask

    task automatic test_fence_idle();
        tick(); bus.fence_v_i = 1'b1;
        nedge();
        tick(); bus.fence_v_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            nedge();
            n_tests++;
            if (bus.fence_done_o !== (k == 1)) begin
                n_fail++; $display("FAIL fence_idle%0d: got done=%b want %b", k, bus.fence_done_o, k == 1);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        tick(); bus.out_ready_i = 1'b0; bus.in_v_i = 1'b1; bus.in_data_i = 8'h6C;
        tick(); bus.in_v_i = 1'b0; bus.fence_v_i = 1'b1;
        tick(); bus.fence_v_i = 1'b0;
        nedge();
        n_tests++;
        if ({bus.in_ready_o, bus.fence_ready_o, bus.out_v_o} !== 3'b001) begin
            n_fail++; $display("FAIL rst_drain_pre: got rdy/frdy/v=%b want 001",
                               {bus.in_ready_o, bus.fence_ready_o, bus.out_v_o});
        end
        tick(); reset_i = 1'b1; reset_done_i = 1'b0;
        nedge();
        n_tests++;
        if ({bus.out_v_o, bus.fence_done_o, bus.in_ready_o} !== 3'b000) begin
            n_fail++; $display("FAIL rst_drain_in: got v/done/rdy=%b want 000",
                               {bus.out_v_o, bus.fence_done_o, bus.in_ready_o});
        end
        tick(); tick(); reset_i = 1'b0; bus.out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            nedge();
            n_tests++;
            if ({bus.out_v_o, bus.fence_done_o, bus.in_ready_o, bus.sent_count_o} !== {3'b001, 32'd0}) begin
                n_fail++; $display("FAIL rst_drain_post%0d: got v=%b done=%b rdy=%b cnt=%0d want 0 0 1 0",
                                   k, bus.out_v_o, bus.fence_done_o, bus.in_ready_o, bus.sent_count_o);
            end
        end
        tick(); reset_done_i = 1'b1; bus.in_v_i = 1'b1; bus.in_data_i = 8'h7D;
        nedge();
        tick(); bus.in_v_i = 1'b0;
        nedge();
        n_tests++;
        if ({bus.out_v_o, bus.out_data_o} !== {1'b1, 8'h7D}) begin
            n_fail++; $display("FAIL rst_resume: got v=%b d=%h want 1 7d", bus.out_v_o, bus.out_data_o);
        end
        tick();
        nedge();
        n_tests++;
        if ({bus.out_v_o, bus.sent_count_o} !== {1'b0, 32'd1}) begin
            n_fail++; $display("FAIL rst_resume_cnt: got v=%b cnt=%0d want 0 1", bus.out_v_o, bus.sent_count_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_credit_cap();
        test_backpressure();
        test_fence();
        test_simul();
        test_fence_idle();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
